// File: rtl/seg7_sampler_decoder.sv
// Samples an active-low 7-segment bus, waits for the pattern to settle, and decodes it back to a hex nibble.
// Optional saturating illegal-pattern counter on err_count when SEG7_ERR_COUNT_EN is defined.
module seg7_sampler_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       valid,
    output logic       blank,
    output logic       illegal,
    output logic       new_digit,
    output logic [7:0] err_count
);

    typedef enum logic {TRACK, LOCKED} state_t;

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [6:0]       SEG_BLANK  = 7'h7F;

    // Active-low g..a glyphs; entry n sits at bits [n*7 +: 7].
    localparam logic [16*7-1:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    state_t           state_reg, state_next;
    logic [6:0]       seg_q_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       digit_reg, digit_next;
    logic             valid_reg, valid_next;
    logic             blank_reg, blank_next;
    logic             illegal_reg, illegal_next;
    logic             new_digit_reg, new_digit_next;
    logic             commit;
    logic             illegal_commit;
    logic [15:0]      glyph_hit;
    logic [3:0]       glyph_value;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_glyph
            assign glyph_hit[gi] = (seg_q_reg == GLYPHS[gi*7 +: 7]);
        end
    endgenerate

    // Glyphs are unique, so at most one hit bit is ever set.
    always_comb begin
        glyph_value = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (glyph_hit[i]) glyph_value = 4'(i);
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (seg_in != seg_q_reg)
            cnt_next = '0;
        else if (cnt_reg != STABLE_MAX)
            cnt_next = cnt_reg + 1'b1;
    end

    always_comb begin
        state_next     = state_reg;
        commit         = 1'b0;
        illegal_commit = 1'b0;
        digit_next     = digit_reg;
        valid_next     = valid_reg;
        blank_next     = blank_reg;
        illegal_next   = illegal_reg;
        new_digit_next = 1'b0;

        case (state_reg)
            TRACK: begin
                // seg_in equals seg_q here, so seg_q is the pattern being committed.
                if (seg_in == seg_q_reg && cnt_next == STABLE_MAX) begin
                    state_next = LOCKED;
                    commit     = 1'b1;
                end
            end
            LOCKED: begin
                if (seg_in != seg_q_reg) state_next = TRACK;
            end
            default: state_next = TRACK;
        endcase

        if (commit) begin
            if (glyph_hit != 16'h0000) begin
                digit_next     = glyph_value;
                valid_next     = 1'b1;
                blank_next     = 1'b0;
                illegal_next   = 1'b0;
                new_digit_next = !valid_reg || (digit_reg != glyph_value);
            end else if (seg_q_reg == SEG_BLANK) begin
                valid_next   = 1'b0;
                blank_next   = 1'b1;
                illegal_next = 1'b0;
            end else begin
                illegal_commit = 1'b1;
                valid_next     = 1'b0;
                blank_next     = 1'b0;
                illegal_next   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= TRACK;
            seg_q_reg     <= SEG_BLANK;
            cnt_reg       <= '0;
            digit_reg     <= 4'h0;
            valid_reg     <= 1'b0;
            blank_reg     <= 1'b0;
            illegal_reg   <= 1'b0;
            new_digit_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            seg_q_reg     <= seg_in;
            cnt_reg       <= cnt_next;
            digit_reg     <= digit_next;
            valid_reg     <= valid_next;
            blank_reg     <= blank_next;
            illegal_reg   <= illegal_next;
            new_digit_reg <= new_digit_next;
        end
    end

`ifdef SEG7_ERR_COUNT_EN
    logic [7:0] err_count_reg;

    always_ff @(posedge clock) begin
        if (reset)
            err_count_reg <= 8'h00;
        else if (illegal_commit && err_count_reg != 8'hFF)
            err_count_reg <= err_count_reg + 8'h01;
    end

    assign err_count = err_count_reg;
`else
    assign err_count = 8'h00;
`endif

    assign digit     = digit_reg;
    assign valid     = valid_reg;
    assign blank     = blank_reg;
    assign illegal   = illegal_reg;
    assign new_digit = new_digit_reg;

endmodule

// File: tb/tb_seg7_sampler_decoder.sv
// Directed bench for seg7_sampler_decoder with STABLE_CYCLES=4: a pattern captured at edge E0 commits at E0+4.
module tb_seg7_sampler_decoder;

    logic       clock;
    logic       reset;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       valid;
    logic       blank;
    logic       illegal;
    logic       new_digit;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    seg7_sampler_decoder #(.STABLE_CYCLES(4), .CNT_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .seg_in    (seg_in),
        .digit     (digit),
        .valid     (valid),
        .blank     (blank),
        .illegal   (illegal),
        .new_digit (new_digit),
        .err_count (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        seg_in = 7'h7F;
        step();
        reset  = 1'b0;
    endtask

    // Compare all status outputs against an expected tuple in one go.
    task automatic expect_out(input string name, input logic [3:0] e_digit, input logic e_valid,
                              input logic e_blank, input logic e_illegal, input logic e_new);
        checks++;
        if ({digit, valid, blank, illegal, new_digit} !== {e_digit, e_valid, e_blank, e_illegal, e_new}) begin
            errors++;
            $display("FAIL %s: got digit=%h valid=%b blank=%b illegal=%b new=%b, want digit=%h valid=%b blank=%b illegal=%b new=%b",
                     name, digit, valid, blank, illegal, new_digit, e_digit, e_valid, e_blank, e_illegal, e_new);
        end
    endtask

    task automatic expect_err(input string name, input logic [7:0] e_on, input logic [7:0] e_off);
        logic [7:0] e;
`ifdef SEG7_ERR_COUNT_EN
        e = e_on;
`else
        e = e_off;
`endif
        checks++;
        if (err_count !== e) begin
            errors++;
            $display("FAIL %s: got err_count=%h want %h", name, err_count, e);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        seg_in = 7'h7F;
        step();
        step();
        expect_out("reset_outputs", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_err("reset_err", 8'h00, 8'h00);
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic_commit();
        seg_in = 7'h24;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("basic_precommit", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step();
        expect_out("basic_commit", 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        expect_out("basic_pulse_end", 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("basic_locked", 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("test_basic_commit done");
    endtask

    task automatic test_short_then_steady();
        do_reset();
        seg_in = 7'h24;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("short_no_2", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        seg_in = 7'h30;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("steady_precommit", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step();
        expect_out("steady_commit_3", 4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
        $display("test_short_then_steady done");
    endtask

    task automatic test_illegal();
        seg_in = 7'h55;
        for (int i = 0; i < 4; i++) step();
        expect_out("illegal_precommit", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("illegal_commit", 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_err("illegal_err", 8'h01, 8'h00);
        $display("test_illegal done");
    endtask

    task automatic test_blank_recommit();
        seg_in = 7'h30;
        for (int i = 0; i < 5; i++) step();
        expect_out("recommit_after_illegal", 4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
        seg_in = 7'h7F;
        for (int i = 0; i < 5; i++) step();
        expect_out("blank_commit", 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
        seg_in = 7'h30;
        for (int i = 0; i < 5; i++) step();
        expect_out("recommit_after_blank", 4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        expect_out("recommit_pulse_end", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("test_blank_recommit done");
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            seg_in = ((i / 2) % 2 == 0) ? 7'h79 : 7'h24;
            step();
            expect_out("bounce_hold", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        $display("test_bounce done");
    endtask

    task automatic test_reset_mid();
        seg_in = 7'h0E;
        step();
        step();
        reset = 1'b1;
        step();
        expect_out("mid_reset_outputs", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_err("mid_reset_err", 8'h00, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("mid_reset_precommit", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step();
        expect_out("mid_reset_commit_F", 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        $display("test_reset_mid done");
    endtask

    task automatic test_err_saturation();
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            seg_in = (n % 2 == 1) ? 7'h55 : 7'h5A;
            for (int i = 0; i < 5; i++) step();
            if (n == 1) expect_err("err_first", 8'h01, 8'h00);
            if (n == 254) expect_err("err_254", 8'hFE, 8'h00);
            if (n == 255) expect_err("err_255", 8'hFF, 8'h00);
        end
        expect_err("err_saturated", 8'hFF, 8'h00);
        expect_out("err_final_status", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        $display("test_err_saturation done");
    endtask

    initial begin
        reset  = 1'b1;
        seg_in = 7'h7F;
        test_reset();
        test_basic_commit();
        test_short_then_steady();
        test_illegal();
        test_blank_recommit();
        test_bounce();
        test_reset_mid();
        test_err_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
